hilo_acc_regfile: RTL and testbench

Parametrised HI/LO special-register file for the CPU core. Supports independent HI-only, LO-only and paired writes. Adds a two-cycle 2W-bit multiply-accumulate/subtract path (MADD/MSUB class) with a busy handshake, a flush for exception cancellation, and optional same-cycle write-to-read bypass. It sits beside the GPR file and is fed by the EX/MEM stage; the hazard unit consumes busy.

---
 rtl/hilo_acc_regfile.sv | 63 ++++++
 tb/tb_hilo_acc_regfile.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_regfile.sv
// hilo_acc_regfile: HI/LO special-register file with two-cycle 2W-bit multiply-accumulate/subtract,
// busy handshake, flush cancellation and optional same-cycle write-to-read bypass.
module hilo_acc_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    input  logic                  flush,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int W2 = 2 * DATA_WIDTH;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hi, r_lo;
    logic [W2-1:0]         r_opnd;
    logic                  r_sub;

    logic          w_accept, w_wr_hi, w_wr_lo, w_acc;
    logic [W2-1:0] w_cur, w_sum;

    always_comb begin
        w_accept = op_valid && (r_state == IDLE) && !flush;
        w_wr_hi  = w_accept && (op == 3'd1 || op == 3'd3);
        w_wr_lo  = w_accept && (op == 3'd2 || op == 3'd3);
        w_acc    = w_accept && (op == 3'd4 || op == 3'd5);
        w_cur    = {r_hi, r_lo};
        // Full-width add/sub so the carry or borrow crosses from LO into HI; wraps silently.
        w_sum    = r_sub ? w_cur - r_opnd : w_cur + r_opnd;
        busy     = (r_state == ACC);
        hi_o     = (BYPASS && w_wr_hi) ? hi_i : r_hi;
        lo_o     = (BYPASS && w_wr_lo) ? lo_i : r_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_sub   <= 1'b0;
        end else if (r_state == ACC) begin
            if (!flush) {r_hi, r_lo} <= w_sum;
            r_state <= IDLE;
        end else begin
            if (w_wr_hi) r_hi <= hi_i;
            if (w_wr_lo) r_lo <= lo_i;
            if (w_acc) begin
                r_opnd  <= {hi_i, lo_i};
                r_sub   <= (op == 3'd5);
                r_state <= ACC;
            end
        end
    end
endmodule

// File: tb/tb_hilo_acc_regfile.sv
// tb_hilo_acc_regfile: directed and randomized checks of both bypass variants against a
// value-level model of the HI/LO pair held as one 64-bit number.
module tb_hilo_acc_regfile;
    logic        clk = 1'b0;
    logic        rst, op_valid, flush;
    logic [2:0]  op;
    logic [31:0] hi_i, lo_i;
    logic        busy1, busy0;
    logic [31:0] hi_o1, lo_o1, hi_o0, lo_o0;

    int checks = 0;
    int errors = 0;

    // Model: architectural 64-bit value plus one pending accumulate.
    logic [63:0] m_val;
    logic [63:0] m_opnd;
    bit          m_pend, m_sub;

    always #5 clk = ~clk;

    hilo_acc_regfile #(.DATA_WIDTH(32), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .hi_i(hi_i), .lo_i(lo_i),
        .flush(flush), .busy(busy1), .hi_o(hi_o1), .lo_o(lo_o1)
    );

    hilo_acc_regfile #(.DATA_WIDTH(32), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .hi_i(hi_i), .lo_i(lo_i),
        .flush(flush), .busy(busy0), .hi_o(hi_o0), .lo_o(lo_o0)
    );

    function automatic logic [31:0] exp_hi(input bit byp);
        return (byp && op_valid && !m_pend && !flush && (op == 3'd1 || op == 3'd3)) ? hi_i : m_val[63:32];
    endfunction

    function automatic logic [31:0] exp_lo(input bit byp);
        return (byp && op_valid && !m_pend && !flush && (op == 3'd2 || op == 3'd3)) ? lo_i : m_val[31:0];
    endfunction

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] h, input logic [31:0] l,
                         input logic f, input logic r);
        op_valid = v; op = o; hi_i = h; lo_i = l; flush = f; rst = r;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_val = '0; m_pend = 0; m_opnd = '0; m_sub = 0;
        end else if (m_pend) begin
            if (!flush) m_val = m_sub ? m_val - m_opnd : m_val + m_opnd;
            m_pend = 0;
        end else if (op_valid && !flush) begin
            if (op == 3'd1) m_val[63:32] = hi_i;
            else if (op == 3'd2) m_val[31:0] = lo_i;
            else if (op == 3'd3) m_val = {hi_i, lo_i};
            else if (op == 3'd4 || op == 3'd5) begin
                m_pend = 1; m_opnd = {hi_i, lo_i}; m_sub = (op == 3'd5);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 3'd0, $urandom, $urandom, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 3'd0, '0, '0, 0, 1);
        tick(); tick();
        idle();
        checks++; if ({hi_o1, lo_o1, busy1} !== 65'd0) begin errors++; $display("FAIL reset_b1 got %h/%h/%b want 0/0/0", hi_o1, lo_o1, busy1); end
        checks++; if ({hi_o0, lo_o0, busy0} !== 65'd0) begin errors++; $display("FAIL reset_b0 got %h/%h/%b want 0/0/0", hi_o0, lo_o0, busy0); end
    endtask

    task automatic test_wr_both();
        drive(1, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
        checks++; if ({hi_o1, lo_o1} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL wrboth_bypass got %h_%h want 12345678_9abcdef0", hi_o1, lo_o1); end
        checks++; if ({hi_o0, lo_o0} !== 64'd0) begin errors++; $display("FAIL wrboth_nobypass got %h_%h want 0_0", hi_o0, lo_o0); end
        tick(); idle();
        checks++; if ({hi_o0, lo_o0} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL wrboth_reg got %h_%h want 12345678_9abcdef0", hi_o0, lo_o0); end
        drive(0, 3'd0, '0, '0, 0, 1);
        tick(); idle();
        checks++; if ({hi_o1, lo_o1, busy1} !== 65'd0) begin errors++; $display("FAIL wrboth_rst got %h/%h/%b want 0/0/0", hi_o1, lo_o1, busy1); end
    endtask

    task automatic test_wr_halves();
        drive(1, 3'd1, 32'hAAAA_AAAA, 32'h1357_9BDF, 0, 0);
        checks++; if (hi_o1 !== 32'hAAAA_AAAA || lo_o1 !== 32'd0) begin errors++; $display("FAIL wrhi_bypass got %h_%h want aaaaaaaa_0", hi_o1, lo_o1); end
        checks++; if (hi_o0 !== 32'd0) begin errors++; $display("FAIL wrhi_nobypass got %h want 0", hi_o0); end
        tick();
        drive(1, 3'd2, 32'h2468_ACE0, 32'h5555_5555, 0, 0);
        checks++; if (hi_o1 !== 32'hAAAA_AAAA || lo_o1 !== 32'h5555_5555) begin errors++; $display("FAIL wrlo_bypass got %h_%h want aaaaaaaa_55555555", hi_o1, lo_o1); end
        checks++; if (lo_o0 !== 32'd0) begin errors++; $display("FAIL wrlo_nobypass got %h want 0", lo_o0); end
        tick(); idle();
        checks++; if ({hi_o0, lo_o0} !== 64'hAAAAAAAA_55555555) begin errors++; $display("FAIL halves_reg got %h_%h want aaaaaaaa_55555555", hi_o0, lo_o0); end
    endtask

    task automatic test_acc(input string name, input logic [63:0] start, input logic [2:0] o, input logic [63:0] want);
        drive(1, 3'd3, start[63:32], start[31:0], 0, 0);
        tick();
        drive(1, o, 32'd0, 32'd1, 0, 0);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL %s_busy_accept got %b want 0", name, busy1); end
        tick(); idle();
        checks++; if (busy1 !== 1'b1 || {hi_o1, lo_o1} !== start) begin errors++; $display("FAIL %s_busy got %b %h_%h want 1 %h", name, busy1, hi_o1, lo_o1, start); end
        tick(); idle();
        checks++; if (busy0 !== 1'b0 || {hi_o0, lo_o0} !== want) begin errors++; $display("FAIL %s_result got %b %h_%h want 0 %h", name, busy0, hi_o0, lo_o0, want); end
    endtask

    task automatic test_stall();
        drive(1, 3'd4, 32'd0, 32'd5, 0, 0);
        tick();
        drive(1, 3'd3, 32'd7, 32'd7, 0, 0);
        checks++; if (busy1 !== 1'b1 || hi_o1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stall_busy got %b %h want 1 ffffffff", busy1, hi_o1); end
        tick();
        checks++; if (busy1 !== 1'b0 || hi_o1 !== 32'd7 || {hi_o0, lo_o0} !== 64'd4) begin errors++; $display("FAIL stall_release got %b %h %h_%h want 0 7 0_4", busy1, hi_o1, hi_o0, lo_o0); end
        tick(); idle();
        checks++; if ({hi_o0, lo_o0} !== {32'd7, 32'd7} || busy0 !== 1'b0) begin errors++; $display("FAIL stall_final got %h_%h %b want 7_7 0", hi_o0, lo_o0, busy0); end
    endtask

    task automatic test_flush_rst();
        drive(1, 3'd4, 32'd0, 32'd1, 0, 0);
        tick();
        drive(0, 3'd0, '0, '0, 1, 0);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL flush_busy got %b want 1", busy1); end
        tick(); idle();
        checks++; if (busy1 !== 1'b0 || {hi_o0, lo_o0} !== {32'd7, 32'd7}) begin errors++; $display("FAIL flush_acc got %b %h_%h want 0 7_7", busy1, hi_o0, lo_o0); end
        drive(1, 3'd5, 32'd3, 32'd3, 0, 0);
        tick();
        drive(0, 3'd0, '0, '0, 0, 1);
        tick(); idle();
        checks++; if (busy1 !== 1'b0 || {hi_o0, lo_o0} !== 64'd0) begin errors++; $display("FAIL rst_acc got %b %h_%h want 0 0_0", busy1, hi_o0, lo_o0); end
        drive(1, 3'd3, 32'd9, 32'd9, 1, 0);
        checks++; if ({hi_o1, lo_o1} !== 64'd0) begin errors++; $display("FAIL flush_idle_bypass got %h_%h want 0_0", hi_o1, lo_o1); end
        tick(); idle();
        checks++; if ({hi_o0, lo_o0} !== 64'd0) begin errors++; $display("FAIL flush_idle_reg got %h_%h want 0_0", hi_o0, lo_o0); end
    endtask

    task automatic test_random();
        logic        v, f, r;
        logic [2:0]  o;
        logic [31:0] h, l;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            v = !r && ($urandom_range(0, 4) != 0);
            f = ($urandom_range(0, 7) == 0);
            o = 3'($urandom_range(0, 7));
            h = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            l = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(v, o, h, l, f, r);
            checks++;
            if (busy1 !== m_pend || hi_o1 !== exp_hi(1) || lo_o1 !== exp_lo(1)) begin
                errors++;
                $display("FAIL rand_b1[%0d] got %b %h_%h want %b %h_%h", i, busy1, hi_o1, lo_o1, m_pend, exp_hi(1), exp_lo(1));
            end
            checks++;
            if (busy0 !== m_pend || hi_o0 !== exp_hi(0) || lo_o0 !== exp_lo(0)) begin
                errors++;
                $display("FAIL rand_b0[%0d] got %b %h_%h want %b %h_%h", i, busy0, hi_o0, lo_o0, m_pend, exp_hi(0), exp_lo(0));
            end
            tick();
        end
    endtask

    initial begin
        m_val = '0; m_opnd = '0; m_pend = 0; m_sub = 0;
        drive(0, 3'd0, '0, '0, 0, 1);
        @(posedge clk); #1;
        test_reset();
        test_wr_both();
        test_wr_halves();
        test_acc("carry_add", 64'h00000000_FFFFFFFF, 3'd4, 64'h00000001_00000000);
        test_acc("carry_sub", 64'h00000001_00000000, 3'd5, 64'h00000000_FFFFFFFF);
        test_acc("wrap_add", 64'hFFFFFFFF_FFFFFFFF, 3'd4, 64'h0);
        test_acc("wrap_sub", 64'h0, 3'd5, 64'hFFFFFFFF_FFFFFFFF);
        test_stall();
        test_flush_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
